// File: rtl/cnratr_pkg.sv
// Shared types and helpers for the segmented transistor-bank ramp controller.
//   state_e     : controller states (idle, stepping, dwelling between steps)
//   code_width  : width of a strength code able to represent 0..n_seg
//   clamp_code  : saturates a requested code at n_seg
package cnratr_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStep,
    StDwell
  } state_e;

  localparam int unsigned DefNSeg = 16;

  function automatic int unsigned code_width(int unsigned n_seg);
    return $clog2(n_seg + 1);
  endfunction

  localparam int unsigned DefCodeW = code_width(DefNSeg);

  function automatic int unsigned clamp_code(int unsigned code, int unsigned n_seg);
    return (code > n_seg) ? n_seg : code;
  endfunction

endpackage

// File: rtl/cnratr_therm_dec.sv
// Binary-to-thermometer decoder for the unit-cell gate enables.
//   code     : applied strength code, 0..N_SEG
//   seg_en   : bit i high when code > i (NCH gates)
//   seg_en_b : bitwise inverse of seg_en (PCH gates)
// Purely combinational; driven from a registered code so the outputs only move
// when the code register does.
module cnratr_therm_dec
  import cnratr_pkg::*;
#(
  parameter int unsigned N_SEG  = DefNSeg,
  parameter int unsigned CODE_W = code_width(N_SEG)
) (
  input  logic [CODE_W-1:0] code,
  output logic [N_SEG-1:0]  seg_en,
  output logic [N_SEG-1:0]  seg_en_b
);

  always_comb begin
    seg_en = '0;
    for (int i = 0; i < int'(N_SEG); i++) begin
      seg_en[i] = (32'(code) > 32'(i));
    end
    seg_en_b = ~seg_en;
  end

endmodule

// File: rtl/cnratr_seg_ramp.sv
// Segmented transistor-bank strength controller.
// Accepts a target code over a valid/ready handshake and moves the applied code
// either in one step (direct) or one segment at a time with a programmable dwell
// (ramp), so the analog bank never sees a large instantaneous change.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready : request handshake; ready only while idle
//   req_code            : target code, values above N_SEG saturate
//   req_ramp            : 1 = ramp one segment at a time, 0 = direct
//   dwell               : extra cycles between ramp steps
//   abort               : freeze a running request at the current code
//   cur_code            : applied code (registered)
//   seg_en, seg_en_b    : thermometer gate enables and their inverse
//   busy                : request in progress
//   done, aborted       : one-cycle completion / abort pulses
module cnratr_seg_ramp
  import cnratr_pkg::*;
#(
  parameter int unsigned N_SEG   = DefNSeg,
  parameter int unsigned CODE_W  = code_width(N_SEG),
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [CODE_W-1:0]  req_code,
  input  logic               req_ramp,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               abort,
  output logic [CODE_W-1:0]  cur_code,
  output logic [N_SEG-1:0]   seg_en,
  output logic [N_SEG-1:0]   seg_en_b,
  output logic               busy,
  output logic               done,
  output logic               aborted
);

  state_e              state_q;
  logic [CODE_W-1:0]   cur_code_q;
  logic [CODE_W-1:0]   tgt_q;
  logic                mode_q;
  logic [DWELL_W-1:0]  dwl_q;
  logic [DWELL_W-1:0]  dwell_cnt_q;
  logic                done_q;
  logic                aborted_q;

  logic [CODE_W-1:0]   req_tgt;
  logic [CODE_W-1:0]   step_code;

  always_comb begin
    req_tgt = CODE_W'(clamp_code(32'(req_code), N_SEG));
    // Only consumed while cur_code_q != tgt_q, so it never wraps.
    step_code = (tgt_q > cur_code_q) ? cur_code_q + CODE_W'(1) : cur_code_q - CODE_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cur_code_q  <= '0;
      tgt_q       <= '0;
      mode_q      <= 1'b0;
      dwl_q       <= '0;
      dwell_cnt_q <= '0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // abort is deliberately not looked at here.
          if (req_valid) begin
            tgt_q  <= req_tgt;
            mode_q <= req_ramp;
            dwl_q  <= dwell;
            if (req_tgt == cur_code_q) begin
              done_q <= 1'b1;
            end else begin
              state_q <= StStep;
            end
          end
        end
        StStep: begin
          if (abort) begin
            state_q   <= StIdle;
            aborted_q <= 1'b1;
          end else if (!mode_q) begin
            cur_code_q <= tgt_q;
            state_q    <= StIdle;
            done_q     <= 1'b1;
          end else begin
            cur_code_q <= step_code;
            if (step_code == tgt_q) begin
              state_q <= StIdle;
              done_q  <= 1'b1;
            end else if (dwl_q != '0) begin
              dwell_cnt_q <= dwl_q;
              state_q     <= StDwell;
            end
          end
        end
        StDwell: begin
          if (abort) begin
            state_q   <= StIdle;
            aborted_q <= 1'b1;
          end else if (dwell_cnt_q == DWELL_W'(1)) begin
            state_q <= StStep;
          end else begin
            dwell_cnt_q <= dwell_cnt_q - DWELL_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    cur_code  = cur_code_q;
    busy      = (state_q != StIdle);
    req_ready = (state_q == StIdle);
    done      = done_q;
    aborted   = aborted_q;
  end

  cnratr_therm_dec #(
    .N_SEG  (N_SEG),
    .CODE_W (CODE_W)
  ) u_therm_dec (
    .code     (cur_code_q),
    .seg_en   (seg_en),
    .seg_en_b (seg_en_b)
  );

endmodule

// File: tb/tb_cnratr_seg_ramp.sv
// Bench for cnratr_seg_ramp: each request is expanded into the full per-cycle
// trajectory of outputs it must produce; a negedge process compares the DUT
// against that trajectory (or against "idle at the last code" when none is
// pending). Directed sequences add literal expectations on top.
module tb_cnratr_seg_ramp;

  localparam int unsigned N_SEG   = 16;
  localparam int unsigned CODE_W  = 5;
  localparam int unsigned DWELL_W = 8;

  logic               clk;
  logic               rst_n;
  logic               req_valid;
  logic               req_ready;
  logic [CODE_W-1:0]  req_code;
  logic               req_ramp;
  logic [DWELL_W-1:0] dwell;
  logic               abort;
  logic [CODE_W-1:0]  cur_code;
  logic [N_SEG-1:0]   seg_en;
  logic [N_SEG-1:0]   seg_en_b;
  logic               busy;
  logic               done;
  logic               aborted;

  cnratr_seg_ramp #(
    .N_SEG   (N_SEG),
    .CODE_W  (CODE_W),
    .DWELL_W (DWELL_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_code  (req_code),
    .req_ramp  (req_ramp),
    .dwell     (dwell),
    .abort     (abort),
    .cur_code  (cur_code),
    .seg_en    (seg_en),
    .seg_en_b  (seg_en_b),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int cur;
    bit busy;
    bit done;
    bit ab;
  } exp_t;

  exp_t exp_q[$];
  int   m_cur;
  bit   m_busy;
  int   checks;
  int   failures;

  function automatic int therm(int c);
    logic [31:0] t;
    t = (32'd1 << c) - 32'd1;
    return int'(t[15:0]);
  endfunction

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s at %0t: got %0d (0x%0h) expected %0d (0x%0h)",
               name, $time, act, act, req, req);
    end
  endtask

  task automatic push(int c, bit b, bit d, bit a);
    exp_t e;
    e.cur  = c;
    e.busy = b;
    e.done = d;
    e.ab   = a;
    exp_q.push_back(e);
  endtask

  // Whole output trajectory of one accepted request, starting with the accept edge.
  task automatic plan(int code, bit ramp, int dwl);
    int tgt;
    int c;
    tgt = (code > int'(N_SEG)) ? int'(N_SEG) : code;
    c   = m_cur;
    if (tgt == c) begin
      push(c, 0, 1, 0);
    end else begin
      push(c, 1, 0, 0);
      if (!ramp) begin
        push(tgt, 0, 1, 0);
      end else begin
        while (c != tgt) begin
          c += (tgt > c) ? 1 : -1;
          if (c == tgt) begin
            push(c, 0, 1, 0);
          end else begin
            push(c, 1, 0, 0);
            repeat (dwl) push(c, 1, 0, 0);
          end
        end
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
      end else begin
        e.cur  = m_cur;
        e.busy = 0;
        e.done = 0;
        e.ab   = 0;
      end
      m_cur  = e.cur;
      m_busy = e.busy;
      chk("cur_code", int'(cur_code), e.cur);
      chk("seg_en", int'(seg_en), therm(e.cur));
      chk("seg_en_b", int'(seg_en_b), therm(e.cur) ^ 32'hFFFF);
      chk("busy", int'(busy), int'(e.busy));
      chk("req_ready", int'(req_ready), int'(!e.busy));
      chk("done", int'(done), int'(e.done));
      chk("aborted", int'(aborted), int'(e.ab));
    end
  end

  // Called at negedge+1 with the DUT idle; returns at negedge+1 after the accept edge.
  task automatic issue(int code, bit ramp, int dwl, bit ab);
    plan(code, ramp, dwl);
    req_valid = 1'b1;
    req_code  = CODE_W'(code);
    req_ramp  = ramp;
    dwell     = DWELL_W'(dwl);
    abort     = ab;
    @(negedge clk);
    #1;
    req_valid = 1'b0;
    abort     = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_busy) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("idle_timeout", int'(exp_q.size() == 0 && !m_busy), 1);
  endtask

  task automatic wait_code(int c, int budget);
    int n;
    n = 0;
    while (m_cur != c && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("wait_code_timeout", m_cur, c);
  endtask

  int exp_traj[8] = '{0, 1, 1, 1, 2, 2, 2, 3};

  initial begin
    checks    = 0;
    failures  = 0;
    m_cur     = 0;
    m_busy    = 0;
    rst_n     = 1'b1;
    req_valid = 1'b0;
    req_code  = '0;
    req_ramp  = 1'b0;
    dwell     = '0;
    abort     = 1'b0;
    #2 rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_cur_code", int'(cur_code), 0);
    chk("rst_seg_en", int'(seg_en), 'h0000);
    chk("rst_seg_en_b", int'(seg_en_b), 'hFFFF);
    chk("rst_req_ready", int'(req_ready), 1);
    chk("rst_busy", int'(busy), 0);

    // Ramp 0 -> 3, dwell 2: codes change at edges 1, 4, 7.
    issue(3, 1, 2, 0);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #1;
      end
      chk("ramp3_traj", int'(cur_code), exp_traj[k]);
      chk("ramp3_done", int'(done), int'(k == 7));
    end
    chk("ramp3_seg_en", int'(seg_en), 'h0007);
    wait_idle(20);

    // Direct 3 -> 10, then direct 10 -> 4 with no intermediate code.
    issue(10, 0, 0, 0);
    wait_idle(20);
    issue(4, 0, 0, 0);
    chk("direct_hold", int'(cur_code), 10);
    @(negedge clk);
    #1;
    chk("direct_code", int'(cur_code), 4);
    chk("direct_done", int'(done), 1);
    chk("direct_seg_en", int'(seg_en), 'h000F);
    wait_idle(20);

    // Clamp 20 -> 16 with a request offered mid-ramp that must be ignored.
    issue(20, 1, 0, 0);
    @(negedge clk);
    #1;
    req_valid = 1'b1;
    req_code  = CODE_W'(0);
    req_ramp  = 1'b0;
    @(negedge clk);
    #1;
    req_valid = 1'b0;
    wait_idle(100);
    chk("clamp_code", int'(cur_code), 16);
    chk("clamp_seg_en", int'(seg_en), 'hFFFF);
    chk("clamp_seg_en_b", int'(seg_en_b), 'h0000);

    // No-op request at the current code.
    issue(16, 1, 0, 0);
    chk("noop_done", int'(done), 1);
    chk("noop_busy", int'(busy), 0);
    wait_idle(20);

    // Abort a 0 -> 8 ramp once the code reads 5.
    issue(0, 0, 0, 0);
    wait_idle(20);
    issue(8, 1, 0, 0);
    wait_code(5, 40);
    if (m_busy) begin
      exp_q.delete();
      push(m_cur, 0, 0, 1);
    end
    abort = 1'b1;
    @(negedge clk);
    #1;
    abort = 1'b0;
    chk("abort_code", int'(cur_code), 5);
    chk("abort_pulse", int'(aborted), 1);
    chk("abort_done", int'(done), 0);
    @(negedge clk);
    #1;
    chk("abort_ready", int'(req_ready), 1);
    chk("abort_pulse_end", int'(aborted), 0);

    // abort in idle alongside a request: the request goes through.
    issue(7, 1, 1, 1);
    wait_idle(40);
    chk("idle_abort_code", int'(cur_code), 7);

    // Asynchronous reset while dwelling at code 6.
    issue(0, 1, 3, 0);
    wait_code(6, 40);
    rst_n = 1'b0;
    #1;
    chk("arst_cur_code", int'(cur_code), 0);
    chk("arst_seg_en", int'(seg_en), 'h0000);
    chk("arst_seg_en_b", int'(seg_en_b), 'hFFFF);
    chk("arst_busy", int'(busy), 0);
    chk("arst_ready", int'(req_ready), 1);
    chk("arst_done", int'(done), 0);
    exp_q.delete();
    m_cur  = 0;
    m_busy = 0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    #1;
    issue(5, 1, 0, 0);
    wait_idle(40);
    chk("post_rst_code", int'(cur_code), 5);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
